// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain arbiter for a bank of first-word-fall-through FIFOs.
// One queue can hold the grant for up to BURST consecutive words. Words are
// forwarded onto a single registered valid/ready stream.
module fifo_rr_drain_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_Q  = 4,
    parameter int unsigned BURST  = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_Q-1:0]          i_empty,
    output logic [NUM_Q-1:0]          o_rden,
    input  logic [NUM_Q*DATA_W-1:0]   i_rddata,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic [$clog2(NUM_Q)-1:0]  o_qid,
    input  logic                      i_ready,
    output logic                      o_busy
);

    localparam int unsigned QID_W = $clog2(NUM_Q);
    localparam int unsigned CNT_W = $clog2(BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [QID_W-1:0]   owner;
    logic [QID_W-1:0]   owner_next;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic [QID_W-1:0]   scan_k;
    logic               scan_hit;
    logic [QID_W-1:0]   sel_k;
    logic               hold_owner;
    logic               any_ne;
    logic               pop;
    logic [DATA_W-1:0]  head_data;

    // First non-empty queue scanning owner+1, owner+2, ... wrapping; owner is checked last
    always_comb begin : scan_p
        logic [QID_W-1:0] idx;
        idx      = '0;
        scan_k   = '0;
        scan_hit = 1'b0;
        for (int unsigned i = 1; i <= NUM_Q; i++) begin
            idx = QID_W'((32'(owner) + i) % NUM_Q);
            if (!scan_hit && !i_empty[idx]) begin
                scan_hit = 1'b1;
                scan_k   = idx;
            end
        end
    end

    // Grant selection and pop decision
    always_comb begin
        any_ne     = |(~i_empty);
        pop        = (!o_valid || i_ready) && any_ne;
        hold_owner = (state == LOCK) && !i_empty[owner] && (burst_cnt < CNT_W'(BURST));
        sel_k      = hold_owner ? owner : scan_k;
        cnt_inc    = burst_cnt + CNT_W'(1);
    end

    // Head word of the selected queue
    always_comb begin
        head_data = '0;
        for (int unsigned k = 0; k < NUM_Q; k++) begin
            if (sel_k == QID_W'(k)) begin
                head_data = i_rddata[k*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register with owner and burst budget
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= QID_W'(NUM_Q - 1);
            burst_cnt <= '0;
            o_busy    <= 1'b0;
        end else begin
            state     <= next_state;
            owner     <= owner_next;
            burst_cnt <= cnt_next;
            o_busy    <= (next_state == LOCK);
        end
    end

    // Next-state logic: burst hold, lock exit and rotation
    always_comb begin
        next_state = state;
        owner_next = owner;
        cnt_next   = burst_cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    owner_next = sel_k;
                    cnt_next   = CNT_W'(1);
                    next_state = (BURST > 1) ? LOCK : IDLE;
                end
            end
            LOCK: begin
                if (hold_owner) begin
                    if (pop) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_W'(BURST)) begin
                            next_state = IDLE;
                        end
                    end
                end else if (pop) begin
                    owner_next = sel_k;
                    cnt_next   = CNT_W'(1);
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Read enable toward the FIFO bank; forced low while in reset
    always_comb begin
        o_rden = '0;
        if (rstn && pop) begin
            o_rden[sel_k] = 1'b1;
        end
    end

    // Output register: capture on pop, drop valid once the word is taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_qid   <= '0;
        end else if (pop) begin
            o_valid <= 1'b1;
            o_data  <= head_data;
            o_qid   <= sel_k;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
